hashtable_bm_updater: RTL and testbench
=======================================

Name: hashtable_bm_updater

Overview:
- Runtime update controller for the hash-table match bitmap: one bit per hash index, 8 bits per memory word.
- Accepts SET / CLR / FLUSH commands from the rule-management path and drives the write port plus a dedicated read port of the bitmap RAM.
- Performs serialised read-modify-write (RMW) updates and a full-table clear.
- Lookup ports are not touched; lookups see old or new word contents, never a partial write.

Parameters:
- NBITS, 15, hash index width.
- BM_AWIDTH, NBITS-3, bitmap word address width; table depth = 2^BM_AWIDTH words.
- RD_LAT, 2, bitmap read latency in cycles (address cycle to data-valid cycle); fixed at 2 for this block.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  0=SET, 1=CLR, 2=FLUSH, 3=NOP
- cmd_idx  in  NBITS  hash index (ignored for FLUSH/NOP)
- done_valid  out  1  one-cycle completion pulse
- done_prev  out  1  bitmap bit value before update (SET/CLR), else 0
- busy  out  1  command in progress (state != IDLE)
- mem_rd_en  out  1  read strobe
- mem_rd_addr  out  BM_AWIDTH  read word address
- mem_rd_data  in  8  read data, valid RD_LAT cycles after the mem_rd_en cycle
- mem_wr_en  out  1  write strobe
- mem_wr_addr  out  BM_AWIDTH  write word address
- mem_wr_data  out  8  write data

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; cmd_ready, done_valid, done_prev, busy, mem_rd_en and mem_wr_en are 0; addresses and data are 0.
  - Reset mid-operation aborts immediately. A partial FLUSH leaves the table partially cleared. No done pulse is issued.
- Handshake: cmd_ready = (state==IDLE) and out of reset. Accept on cmd_valid & cmd_ready. Command fields are captured at accept; the command is held internally.
- All outputs are registered. Notation: cycle c0 = accept edge.
- FSM states: IDLE, RD, W1, W2, WR, FL, DONE.
- SET/CLR path: IDLE → RD → W1 → W2 → WR → IDLE.
  - c1 (RD): mem_rd_en=1, mem_rd_addr=idx[NBITS-1:3].
  - c2 (W1): no memory action.
  - c3 (W2): mem_rd_data sampled.
  - c4 (WR): mem_wr_en=1, mem_wr_addr = same word.
    - SET: mem_wr_data = rd | (1<<idx[2:0]).
    - CLR: mem_wr_data = rd & ~(1<<idx[2:0]).
  - c4 also: done_valid=1, done_prev = rd[idx[2:0]].
  - c5: cmd_ready=1.
  - The write is always issued, even when the bit already holds the target value.
- FLUSH path: IDLE → FL → IDLE.
  - Counter runs 0..2^BM_AWIDTH-1, one word per cycle.
  - c1..cW: mem_wr_en=1, mem_wr_addr=counter, mem_wr_data=0, where W=2^BM_AWIDTH.
  - done_valid=1 on the last write cycle (addr = all ones); done_prev=0.
  - cmd_ready=1 the following cycle.
  - The counter does not wrap: the terminal address ends the sweep.
- NOP path: IDLE → DONE → IDLE.
  - c1: done_valid=1, done_prev=0, no memory access.
  - c2: cmd_ready=1.
- Ordering and hazards:
  - Commands are strictly serialised; the next read is always issued after the previous write, so there is no read-after-write hazard.
  - mem_rd_en and mem_wr_en are never both high in the same cycle.
- busy=1 from c1 through the done cycle inclusive; busy=0 whenever cmd_ready=1.
- cmd_valid while cmd_ready=0 is ignored. The upstream holds the command until the handshake completes.
- done_valid is exactly one cycle per accepted command and carries no backpressure.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release → cmd_ready=1 on the first post-reset edge; all strobes 0; busy=0.
- SET: word 0x05 holds 0x00, cmd SET idx=0x2B → mem_rd_en at c1 with addr 0x05; mem_wr_en at c4 with addr 0x05, data 0x08; done_prev=0; cmd_ready at c5.
- CLR: word 0x05 holds 0xFF, cmd CLR idx=0x2F → mem_wr_data=0x7F at c4; done_prev=1.
- Back-to-back on the same word: SET idx=0x28, then SET idx=0x29 presented with cmd_valid held high → second accept at c5, second read returns 0x01, second write data 0x03; no overlapping strobes.
- FLUSH with NBITS=6 (8 words): mem_wr_en high for exactly 8 consecutive cycles, addrs 0..7, data 0; done_valid with addr 7; cmd_ready next cycle; a model memory reads all zero afterwards.
- Abort: FLUSH (NBITS=6), assert rst_n=0 while writing addr 3 → next edge all strobes 0, no done_valid, state IDLE; after release a NOP completes with done_valid at c1.

Source files
------------

// File: rtl/hashtable_bm_updater.sv
// Runtime update controller for the hash-table match bitmap (8 bits per RAM word).
// Serialises SET/CLR read-modify-write updates, full-table FLUSH and NOP commands.
module hashtable_bm_updater #(
  parameter int NBITS     = 15,
  parameter int BM_AWIDTH = NBITS - 3,
  parameter int RD_LAT    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [NBITS-1:0]     cmd_idx,
  output logic                 done_valid,
  output logic                 done_prev,
  output logic                 busy,
  output logic                 mem_rd_en,
  output logic [BM_AWIDTH-1:0] mem_rd_addr,
  input  logic [7:0]           mem_rd_data,
  output logic                 mem_wr_en,
  output logic [BM_AWIDTH-1:0] mem_wr_addr,
  output logic [7:0]           mem_wr_data,
  output logic [2:0]           dbg_state
);

  // Handshake: a command is accepted on a clk edge where cmd_valid and cmd_ready
  // are both high; op and idx are captured there and held until the done cycle.
  // cmd_ready is high only in IDLE out of reset; done_valid has no backpressure.

  // The W1/W2 wait states are sized for a two-cycle read pipeline.
  if (RD_LAT != 2) begin : g_rd_lat_chk
    $error("hashtable_bm_updater: only RD_LAT=2 is supported");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_W1   = 3'd2,
    S_W2   = 3'd3,
    S_WR   = 3'd4,
    S_FL   = 3'd5,
    S_DONE = 3'd6
  } state_e;

  localparam logic [1:0] OP_SET   = 2'd0;
  localparam logic [1:0] OP_CLR   = 2'd1;
  localparam logic [1:0] OP_FLUSH = 2'd2;

  localparam logic [BM_AWIDTH-1:0] ADDR_MAX = {BM_AWIDTH{1'b1}};

  state_e                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [NBITS-1:0]       idx_q, idx_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   busy_q, busy_d;
  logic                   done_valid_q, done_valid_d;
  logic                   done_prev_q, done_prev_d;
  logic                   rd_en_q, rd_en_d;
  logic [BM_AWIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                   wr_en_q, wr_en_d;
  logic [BM_AWIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic [7:0]             bit_mask;

  assign bit_mask = 8'd1 << idx_q[2:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      idx_q        <= '0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_valid_q <= 1'b0;
      done_prev_q  <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      done_valid_q <= done_valid_d;
      done_prev_q  <= done_prev_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  // Every output is computed one cycle ahead so that the ports come straight from flops.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    idx_d        = idx_q;
    done_valid_d = 1'b0;
    done_prev_d  = 1'b0;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d  = cmd_op;
          idx_d = cmd_idx;
          case (cmd_op)
            OP_SET, OP_CLR: begin
              state_d   = S_RD;
              rd_en_d   = 1'b1;
              rd_addr_d = cmd_idx[NBITS-1:3];
            end
            OP_FLUSH: begin
              state_d      = S_FL;
              wr_en_d      = 1'b1;
              wr_addr_d    = '0;
              wr_data_d    = '0;
              done_valid_d = (ADDR_MAX == '0);
            end
            default: begin
              state_d      = S_DONE;
              done_valid_d = 1'b1;
            end
          endcase
        end
      end
      S_RD: state_d = S_W1;
      S_W1: state_d = S_W2;
      S_W2: begin
        // Read data lands this cycle; merge the target bit and write the word back.
        state_d      = S_WR;
        wr_en_d      = 1'b1;
        wr_addr_d    = idx_q[NBITS-1:3];
        wr_data_d    = (op_q == OP_SET) ? (mem_rd_data | bit_mask)
                                        : (mem_rd_data & ~bit_mask);
        done_valid_d = 1'b1;
        done_prev_d  = mem_rd_data[idx_q[2:0]];
      end
      S_WR: state_d = S_IDLE;
      S_FL: begin
        // The write address doubles as the sweep counter; the all-ones word ends it.
        if (wr_addr_q == ADDR_MAX) begin
          state_d = S_IDLE;
        end else begin
          wr_en_d      = 1'b1;
          wr_addr_d    = wr_addr_q + 1'b1;
          wr_data_d    = '0;
          done_valid_d = ((wr_addr_q + 1'b1) == ADDR_MAX);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign done_valid  = done_valid_q;
  assign done_prev   = done_prev_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = rd_addr_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_hashtable_bm_updater.sv
// Bench for hashtable_bm_updater (NBITS=6, 8 words): RAM model, bit-level reference
// bitmap, directed plus randomized command sequences.
module tb_hashtable_bm_updater;

  localparam int NBITS = 6;
  localparam int AW    = 3;
  localparam int WORDS = 8;
  localparam logic [1:0] OP_SET   = 2'd0;
  localparam logic [1:0] OP_CLR   = 2'd1;
  localparam logic [1:0] OP_FLUSH = 2'd2;
  localparam logic [1:0] OP_NOP   = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = OP_NOP;
  logic [NBITS-1:0] cmd_idx = '0;
  logic             done_valid, done_prev, busy;
  logic             mem_rd_en, mem_wr_en;
  logic [AW-1:0]    mem_rd_addr, mem_wr_addr;
  logic [7:0]       mem_rd_data, mem_wr_data;
  logic [2:0]       dbg_state;

  hashtable_bm_updater #(.NBITS(NBITS), .BM_AWIDTH(AW), .RD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
    .done_valid(done_valid), .done_prev(done_prev), .busy(busy),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .dbg_state(dbg_state)
  );

  // ---------------- bitmap RAM model (2-cycle read) ----------------
  logic [7:0]    mem [WORDS];
  logic [7:0]    rd_s1;
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [7:0]    pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    rd_s1       <= mem_rd_en ? mem[mem_rd_addr] : 8'($urandom);
    mem_rd_data <= rd_s1;
  end

  // ---------------- scoreboard ----------------
  int n_pass = 0, n_total = 0, n_fail = 0;
  int exp_done = 0, seen_done = 0;
  logic [WORDS*8-1:0] ref_bm = '0;  // one bit per hash index

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rd_wr_overlap", {31'b0, mem_rd_en & mem_wr_en}, 32'd0);
      chk("busy_with_ready", {31'b0, busy & cmd_ready}, 32'd0);
    end
    if (done_valid === 1'b1) seen_done++;
  end

  // ---------------- driver tasks (enter and leave just after a negedge) ----------------
  task automatic preload(input int w, input logic [7:0] v);
    pre_en = 1'b1; pre_addr = 3'(w); pre_data = v;
    @(negedge clk);
    pre_en = 1'b0;
    ref_bm[w*8 +: 8] = v;
  endtask

  task automatic check_words(input string tag);
    for (int w = 0; w < WORDS; w++) chk(tag, mem[w], ref_bm[w*8 +: 8]);
  endtask

  task automatic strobes(input string tag, input logic rd, input logic wr, input logic dv);
    chk({tag, "_rd_en"}, mem_rd_en, rd);
    chk({tag, "_wr_en"}, mem_wr_en, wr);
    chk({tag, "_done"}, done_valid, dv);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_ready"}, cmd_ready, 1'b0);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [NBITS-1:0] idx, input bit chain,
                         input logic [1:0] n_op, input logic [NBITS-1:0] n_idx);
    int t;
    int w;
    logic [7:0] exp_word;
    logic exp_prev;
    cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait", {31'b0, t < 40}, 32'd1);
    w = int'(idx[NBITS-1:3]);
    exp_prev = ref_bm[idx];
    if (op == OP_SET) ref_bm[idx] = 1'b1;
    else if (op == OP_CLR) ref_bm[idx] = 1'b0;
    else if (op == OP_FLUSH) ref_bm = '0;
    exp_word = ref_bm[w*8 +: 8];
    exp_done++;
    @(posedge clk);
    @(negedge clk);  // c1
    cmd_valid = chain;
    if (chain) begin cmd_op = n_op; cmd_idx = n_idx; end
    else begin cmd_op = 2'($urandom); cmd_idx = NBITS'($urandom); end
    case (op)
      OP_SET, OP_CLR: begin
        strobes("rmw_c1", 1'b1, 1'b0, 1'b0);
        chk("rmw_c1_rd_addr", mem_rd_addr, w);
        @(negedge clk); strobes("rmw_c2", 1'b0, 1'b0, 1'b0);
        @(negedge clk); strobes("rmw_c3", 1'b0, 1'b0, 1'b0);
        @(negedge clk); strobes("rmw_c4", 1'b0, 1'b1, 1'b1);
        chk("rmw_c4_wr_addr", mem_wr_addr, w);
        chk("rmw_c4_wr_data", mem_wr_data, exp_word);
        chk("rmw_c4_prev", done_prev, exp_prev);
      end
      OP_FLUSH: begin
        for (int k = 0; k < WORDS; k++) begin
          if (k > 0) @(negedge clk);
          strobes("flush", 1'b0, 1'b1, k == WORDS - 1);
          chk("flush_addr", mem_wr_addr, k);
          chk("flush_data", mem_wr_data, 32'd0);
          chk("flush_prev", done_prev, 32'd0);
        end
      end
      default: begin
        strobes("nop_c1", 1'b0, 1'b0, 1'b1);
        chk("nop_prev", done_prev, 32'd0);
      end
    endcase
    @(negedge clk);
    chk("end_ready", cmd_ready, 1'b1);
    chk("end_busy", busy, 1'b0);
    chk("end_done", done_valid, 1'b0);
    chk("end_wr_en", mem_wr_en, 1'b0);
    chk("end_rd_en", mem_rd_en, 1'b0);
  endtask

  function automatic logic [1:0] rand_op();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return OP_SET;
    if (r < 7) return OP_CLR;
    if (r == 7) return OP_FLUSH;
    return OP_NOP;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] cur_op, nxt_op;
    logic [NBITS-1:0] cur_idx, nxt_idx;
    bit ch;
    int done_before;

    // reset then idle
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done_valid, 1'b0);
    chk("rst_prev", done_prev, 1'b0);
    chk("rst_rd_en", mem_rd_en, 1'b0);
    chk("rst_wr_en", mem_wr_en, 1'b0);
    chk("rst_rd_addr", mem_rd_addr, 32'd0);
    chk("rst_wr_addr", mem_wr_addr, 32'd0);
    chk("rst_wr_data", mem_wr_data, 32'd0);
    chk("rst_state", dbg_state, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1'b1);
    chk("post_rst_busy", busy, 1'b0);

    // FLUSH over a dirty table
    for (int w = 0; w < WORDS; w++) preload(w, 8'($urandom_range(1, 255)));
    run_cmd(OP_FLUSH, 6'h15, 1'b0, OP_NOP, '0);
    check_words("flush_mem");

    // SET / CLR directed cases
    preload(5, 8'h00);
    run_cmd(OP_SET, 6'h2B, 1'b0, OP_NOP, '0);
    chk("set_word5", mem[5], 8'h08);
    preload(5, 8'hFF);
    run_cmd(OP_CLR, 6'h2F, 1'b0, OP_NOP, '0);
    chk("clr_word5", mem[5], 8'h7F);

    // back-to-back on the same word, cmd_valid held
    preload(5, 8'h00);
    run_cmd(OP_SET, 6'h28, 1'b1, OP_SET, 6'h29);
    run_cmd(OP_SET, 6'h29, 1'b0, OP_NOP, '0);
    chk("b2b_word5", mem[5], 8'h03);

    // NOP
    run_cmd(OP_NOP, 6'h3F, 1'b0, OP_NOP, '0);

    // randomized sequence
    cur_op = rand_op();
    cur_idx = NBITS'($urandom);
    for (int i = 0; i < 30; i++) begin
      nxt_op = rand_op();
      nxt_idx = NBITS'($urandom);
      ch = (i < 29) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_cmd(cur_op, cur_idx, ch, nxt_op, nxt_idx);
      if (!ch) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          chk("gap_ready", cmd_ready, 1'b1);
        end
      end
      cur_op = nxt_op;
      cur_idx = nxt_idx;
    end
    check_words("rand_mem");

    // abort a FLUSH while it writes word 3
    for (int w = 0; w < WORDS; w++) preload(w, 8'hFF);
    done_before = seen_done;
    cmd_valid = 1'b1; cmd_op = OP_FLUSH; cmd_idx = '0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_wr_en", mem_wr_en, 1'b1);
    chk("abort_wr_addr", mem_wr_addr, 32'd3);
    rst_n = 1'b0;
    ref_bm[0 +: 32] = '0;
    @(negedge clk);
    chk("abort_rd_en", mem_rd_en, 1'b0);
    chk("abort_wr_en0", mem_wr_en, 1'b0);
    chk("abort_done", done_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_state", dbg_state, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_done", seen_done, done_before);
    chk("abort_ready", cmd_ready, 1'b1);
    check_words("abort_mem");
    run_cmd(OP_NOP, '0, 1'b0, OP_NOP, '0);

    chk("done_count", seen_done, exp_done);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
